// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one LSB-first parallel-to-serial shifter between NUM_REQ requesters.
// Optional even-parity trailer bit enabled by defining P2S_PARITY_EN.
module p2s_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             serial_out,
  output logic                             serial_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int IDX_W  = ID_W + 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int GCNT_W = 3;
`ifdef P2S_PARITY_EN
  localparam int LAST_BIT = DATA_W;
`else
  localparam int LAST_BIT = DATA_W - 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [DATA_W-1:0]   shreg_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [GCNT_W-1:0]   gap_cnt_r;
  logic [ID_W-1:0]     winner_s;
  logic                any_valid_s;
  logic [IDX_W-1:0]    idx_s;

`ifdef P2S_PARITY_EN
  logic                par_r;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Winner search: walk downward so the last hit is the first valid at or after ptr.
  always_comb begin
    winner_s    = '0;
    any_valid_s = 1'b0;
    idx_s       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s       = {1'b0, ptr_r} + IDX_W'(i);
      idx_s       = (idx_s >= IDX_W'(NUM_REQ)) ? (idx_s - IDX_W'(NUM_REQ)) : idx_s;
      winner_s    = req_valid[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : winner_s;
      any_valid_s = any_valid_s | req_valid[idx_s[ID_W-1:0]];
    end
  end

  // One-hot accept strobe, only offered in IDLE and forced low while reset is held.
  always_comb begin
    req_ready           = '0;
    req_ready[winner_s] = rst_n & (state_r == ST_IDLE) & any_valid_s;
  end

  // Frame sequencer: accept, shift data bits (plus optional parity), then idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      gap_cnt_r    <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
`ifdef P2S_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            serial_out   <= req_data[winner_s][0];
            shreg_r      <= req_data[winner_s] >> 1;
            serial_valid <= 1'b1;
            bit_cnt_r    <= '0;
            grant_id     <= winner_s;
            ptr_r        <= (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : (winner_s + ID_W'(1));
            busy         <= 1'b1;
            state_r      <= ST_SHIFT;
`ifdef P2S_PARITY_EN
            par_r        <= even_parity(req_data[winner_s]);
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_r == CNT_W'(LAST_BIT)) begin
            serial_valid <= 1'b0;
            serial_out   <= 1'b0;
            bit_cnt_r    <= '0;
            gap_cnt_r    <= '0;
            if (GAP_CYC > 0) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            shreg_r   <= shreg_r >> 1;
`ifdef P2S_PARITY_EN
            serial_out <= (bit_cnt_r == CNT_W'(DATA_W - 1)) ? par_r : shreg_r[0];
`else
            serial_out <= shreg_r[0];
`endif
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GCNT_W'(GAP_CYC - 1)) begin
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            gap_cnt_r <= '0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GCNT_W'(1);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          serial_valid <= 1'b0;
          serial_out   <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Randomized scoreboard bench for p2s_rr_scheduler: a cycle-level reference model predicts
// accept strobes, grants and frame timing; a monitor deserializes frames and checks them.
module tb_p2s_rr_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 1;
`ifdef P2S_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif
  localparam int PERIOD = FRAME + GAP + 1;

  typedef struct {
    int         start;
    int         gid;
    logic [7:0] data;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_ready;
  logic                   serial_out;
  logic                   serial_valid;
  logic [1:0]             grant_id;
  logic                   busy;

  p2s_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYC(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mptr = 0;
  int         next_free = 0;
  int         exp_gid = 0;
  int         hs_id = -1;
  exp_t       sb[$];
  int         gq[$];
  logic [7:0] wq[N][$];
  bit         en[N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = rst_n ? cyc + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && wq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i]  = wq[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'($urandom);
      end
    end
  endfunction

  // One clock of the reference model: predict the accept, compare, then update stimulus.
  task automatic step();
    int           w;
    logic [N-1:0] er;
    @(negedge clk);
    w  = -1;
    er = '0;
    if (cyc >= next_free) begin
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req_valid[(mptr + i) % N]) w = (mptr + i) % N;
      end
    end
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(cyc < next_free));
    chk("grant_id", 32'(grant_id), 32'(exp_gid));
    hs_id = w;
    if (w >= 0) begin
      sb.push_back('{start: cyc + 1, gid: w, data: wq[w][0]});
      gq.push_back(w);
      exp_gid   = w;
      mptr      = (w + 1) % N;
      next_free = cyc + PERIOD;
    end
    @(posedge clk);
    #1;
    if (w >= 0) void'(wq[w].pop_front());
    drive();
  endtask

  function automatic bit all_done();
    bit d;
    d = (sb.size() == 0) && (cyc >= next_free);
    for (int i = 0; i < N; i++) d = d && (wq[i].size() == 0);
    return d;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    drive();
    while (!all_done() && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending frames expected 0", sb.size());
    end
    repeat (2) step();
  endtask

  // Monitor: deserialize frames LSB first and compare against the scoreboard.
  initial begin
    int             mcnt;
    int             mstart;
    logic [FRAME-1:0] mbits;
    exp_t           e;
    mcnt   = 0;
    mstart = 0;
    mbits  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcnt = 0;
      end else if (serial_valid) begin
        if (mcnt == 0) mstart = cyc;
        mbits = {serial_out, mbits[FRAME-1:1]};
        mcnt++;
        if (mcnt == FRAME) begin
          mcnt = 0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame at cycle %0d expected none", mstart);
          end else begin
            e = sb.pop_front();
            chk("frame_start", 32'(mstart), 32'(e.start));
            chk("frame_data", 32'(mbits[DW-1:0]), 32'(e.data));
`ifdef P2S_PARITY_EN
            chk("parity_bit", 32'(mbits[DW]), 32'(^e.data));
`endif
          end
        end
      end else begin
        chk("idle_serial_out", 32'(serial_out), 32'd0);
        if (mcnt != 0) begin
          checks++;
          errors++;
          $display("FAIL short_frame: got %0d bits expected %0d", mcnt, FRAME);
          mcnt = 0;
        end
      end
    end
  end

  initial begin
    int ord[5];
    int wrap[3];
    int hs_wait;
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_serial_valid", 32'(serial_valid), 32'd0);
    chk("rst_serial_out", 32'(serial_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: all four continuously valid from ptr 0.
    for (int i = 0; i < N; i++) begin
      wq[i].push_back(8'(8'h11 * (i + 1)));
      wq[i].push_back(8'(8'h11 * (i + 1)));
    end
    gq.delete();
    drain();
    ord = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(gq.size()), 32'd8);
    for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_order", 32'(gq[k]), 32'(ord[k]));

    // Single word from requester 0.
    wq[0].push_back(8'hA5);
    drain();

    // No requests for 20 cycles.
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    drive();
    repeat (20) step();

    // Wrap and skip: move ptr to 3, then only 0 and 2 request.
    wq[2].push_back(8'h42);
    drain();
    wq[0].push_back(8'h81);
    wq[0].push_back(8'h18);
    wq[2].push_back(8'h7E);
    gq.delete();
    drain();
    wrap = '{0, 2, 0};
    chk("wrap_count", 32'(gq.size()), 32'd3);
    for (int k = 0; k < 3 && k < gq.size(); k++) chk("wrap_order", 32'(gq[k]), 32'(wrap[k]));

    // Reset in the middle of a frame from requester 2.
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    en[2] = 1'b1;
    wq[2].push_back(8'h3C);
    drive();
    hs_wait = 0;
    do begin
      step();
      hs_wait++;
    end while (hs_id != 2 && hs_wait < 50);
    chk("midrst_grant_seen", 32'(hs_id), 32'd2);
    repeat (3) step();
    en[0] = 1'b1;
    wq[0].push_back(8'h5A);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_serial_valid", 32'(serial_valid), 32'd0);
    chk("midrst_serial_out", 32'(serial_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    mptr      = 0;
    next_free = 0;
    exp_gid   = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en[2] = 1'b1;
    wq[2].push_back(8'hC3);
    drive();
    gq.delete();
    drain();
    chk("post_rst_first_grant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);

    // Randomized traffic with occasional withdrawn requests.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (wq[r].size() < 3) wq[r].push_back(8'($urandom));
      end
      if ($urandom_range(0, 15) == 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        en[r] = ~en[r];
      end
      drive();
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/p2s_rr_scheduler.md
Name: p2s_rr_scheduler

Overview:
- Shares one LSB-first parallel-to-serial shift path between NUM_REQ byte requesters.
- Round-robin arbitration; each requester uses a valid/ready handshake.
- Accepts one word per frame, shifts it out one bit per clock, then inserts a fixed idle gap.
- Sits in front of the serial link; its serial output and the accepted parallel words feed the existing parallel/serial monitors and scoreboard.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bits per word.
- GAP_CYC, 1, idle cycles forced between frames (0..7).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ x DATA_W  per-requester word (packed array, index = requester).
- req_ready  output  NUM_REQ  one-hot accept strobe.
- serial_out  output  1  serial data, LSB first.
- serial_valid  output  1  high while serial_out carries a frame bit.
- grant_id  output  $clog2(NUM_REQ)  requester owning the current or last frame.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (asynchronous, effective immediately, also mid-frame), all to 0: req_ready, serial_out, serial_valid, grant_id, busy, bit counter, gap counter. Round-robin pointer resets to 0, so requester 0 has top priority. The state machine goes to IDLE.
- States: IDLE, SHIFT, GAP.
- IDLE arbitration:
  - Winner = first asserted req_valid, searching upward from ptr and wrapping modulo NUM_REQ.
  - req_ready is combinational from req_valid and ptr: exactly one bit high (the winner), all zero if no req_valid.
  - Handshake = req_valid[w] & req_ready[w] in cycle T. On the T edge: load shift register with req_data[w], grant_id <= w, ptr <= (w+1) mod NUM_REQ, state <= SHIFT.
- SHIFT:
  - serial_valid = 1 and serial_out = shreg[0], both registered.
  - Bit 0 appears in cycle T+1; bit k appears in cycle T+1+k; last bit in cycle T+DATA_W.
  - req_ready = 0 throughout.
  - After the last bit: state <= GAP if GAP_CYC > 0, else IDLE.
- GAP:
  - serial_valid = 0, serial_out = 0, req_ready = 0.
  - Lasts exactly GAP_CYC cycles, then IDLE.
- busy = 1 in SHIFT and GAP, 0 in IDLE.
- serial_out is 0 whenever serial_valid = 0; it is never X after reset.
- Back-to-back timing: with GAP_CYC = 1 and continuous requests, a new handshake occurs every DATA_W+2 cycles (DATA_W shift, 1 gap, 1 IDLE accept cycle).
- Requester behaviour: requesters hold req_valid and req_data stable until accepted. A requester that drops req_valid before being accepted is simply skipped. req_data of non-winners is ignored.
- All req_valid asserted: grants rotate 0,1,2,3,0,...
- Single requester k continuously valid: it is granted every frame. ptr still advances to k+1 each frame.
- req_valid asserted while busy has no effect until IDLE; arbitration uses the req_valid values sampled in the IDLE cycle.
- grant_id holds its value through GAP and IDLE until the next handshake.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined: one even-parity bit (XOR of the DATA_W data bits) is sent in the cycle after bit DATA_W-1, with serial_valid = 1. Frame length becomes DATA_W+1 cycles and the back-to-back period becomes DATA_W+3.
- Not defined: no parity bit; the frame is exactly DATA_W bits. No parity logic is synthesized.

Test Plan:
- Reset mid-frame: with requester 2 shifting, assert rst_n=0 at bit 3 -> same-cycle serial_valid=0, serial_out=0, busy=0, req_ready=0; after release, ptr=0 and the first grant goes to requester 0 if it is valid.
- Single word: req_valid=4'b0001, req_data[0]=8'hA5 -> req_ready[0]=1 for 1 cycle; serial_out = 1,0,1,0,0,1,0,1 over cycles T+1..T+8 with serial_valid=1; serial_valid=0 at T+9; busy=1 from T+1 through T+9.
- Round-robin fairness: all four valid continuously, data = 8'h11*(i+1) -> grant order 0,1,2,3,0; each frame's deserialized byte equals that requester's data; one handshake every 10 cycles.
- Wrap and skip: ptr=3, req_valid=4'b0101 -> grant 0, then grant 2, then grant 0; requester 3 is never granted.
- No requests: req_valid=0 for 20 cycles -> req_ready=0, serial_valid=0, busy=0, grant_id unchanged.
- Parity (P2S_PARITY_EN): data 8'h07 -> 9th bit = 1; data 8'h03 -> 9th bit = 0; serial_valid high for 9 cycles per frame.
